if_id_pipe_reg: RTL and testbench

//   IF/ID pipeline register of the 5-stage MIPS-style core.

---
 rtl/if_id_pipe_reg_pkg.sv | 10 +
 rtl/if_id_pipe_reg_pipe_reg.sv | 34 +++
 rtl/if_id_pipe_reg.sv | 44 ++++
 tb/tb_if_id_pipe_reg.sv | 113 +++++++++++
 4 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// rtl/if_id_pipe_reg_pkg.sv - shared pipeline constants for the inter-stage registers
package if_id_pipe_reg_pkg;

  localparam int DATA_W = 32;

  // All-zero word decodes as sll $0,$0,0, so it doubles as the bubble.
  localparam logic [DATA_W-1:0] NOP_INST   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] PC_RST_VAL = {DATA_W{1'b0}};

endpackage

// File: rtl/if_id_pipe_reg_pipe_reg.sv
// rtl/if_id_pipe_reg_pipe_reg.sv - generic W-bit stage flop with async reset and sync clear
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d;
    if (clr) begin
      data_d = CLR_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register; flush turns the decode slot into a NOP bubble
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int MSB = DATA_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           flush,
  input  logic [MSB-1:0] IF_next_pc,
  input  logic [MSB-1:0] IF_inst,
  output logic [MSB-1:0] ID_next_pc,
  output logic [MSB-1:0] ID_inst
);

  logic clr;

  assign clr = flush;

  pipe_reg #(
    .W       (MSB),
    .RST_VAL (MSB'(PC_RST_VAL)),
    .CLR_VAL (MSB'(PC_RST_VAL))
  ) u_pc_reg (
    .clk (i_clk),
    .rst (i_rst),
    .clr (clr),
    .d   (IF_next_pc),
    .q   (ID_next_pc)
  );

  pipe_reg #(
    .W       (MSB),
    .RST_VAL (MSB'(NOP_INST)),
    .CLR_VAL (MSB'(NOP_INST))
  ) u_inst_reg (
    .clk (i_clk),
    .rst (i_rst),
    .clr (clr),
    .d   (IF_inst),
    .q   (ID_inst)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - directed self-checking bench for if_id_pipe_reg
module tb_if_id_pipe_reg;

  logic        i_clk;
  logic        i_rst;
  logic        flush;
  logic [31:0] IF_next_pc;
  logic [31:0] IF_inst;
  logic [31:0] ID_next_pc;
  logic [31:0] ID_inst;

  int errors = 0;
  int checks = 0;

  if_id_pipe_reg #(.MSB(32)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .flush      (flush),
    .IF_next_pc (IF_next_pc),
    .IF_inst    (IF_inst),
    .ID_next_pc (ID_next_pc),
    .ID_inst    (ID_inst)
  );

  initial i_clk = 1'b1;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    flush      = 1'b0;
    IF_next_pc = 32'd4;
    IF_inst    = 32'd5;

    #1;  // t=1
    check("rst_pc_t1", ID_next_pc, 32'h0);
    check("rst_inst_t1", ID_inst, 32'h0);
    #3;  // t=4
    check("rst_pc_t4", ID_next_pc, 32'h0);
    check("rst_inst_t4", ID_inst, 32'h0);
    #1;  // t=5
    i_rst = 1'b0;

    #6;  // t=11
    check("load_pc", ID_next_pc, 32'd4);
    check("load_inst", ID_inst, 32'd5);

    #4;  // t=15
    IF_next_pc = 32'd8;
    IF_inst    = 32'd6;
    flush      = 1'b1;
    #6;  // t=21
    check("flush_pc", ID_next_pc, 32'h0);
    check("flush_inst", ID_inst, 32'h0);

    #4;  // t=25
    flush = 1'b0;
    #6;  // t=31
    check("resume_pc", ID_next_pc, 32'd8);
    check("resume_inst", ID_inst, 32'd6);
    #10; // t=41
    check("hold_pc", ID_next_pc, 32'd8);
    check("hold_inst", ID_inst, 32'd6);

    #2;  // t=43
    i_rst = 1'b1;
    #1;  // t=44
    check("async_rst_pc", ID_next_pc, 32'h0);
    check("async_rst_inst", ID_inst, 32'h0);
    #1;  // t=45
    flush = 1'b1;
    #6;  // t=51
    check("rst_flush_pc", ID_next_pc, 32'h0);
    check("rst_flush_inst", ID_inst, 32'h0);

    #2;  // t=53
    i_rst      = 1'b0;
    flush      = 1'b0;
    IF_next_pc = 32'h0000_1000;
    IF_inst    = 32'hDEAD_BEEF;
    #2;  // t=55: flush pulse between edges must be ignored
    flush = 1'b1;
    #2;  // t=57
    flush = 1'b0;
    #4;  // t=61
    check("b2b0_pc", ID_next_pc, 32'h0000_1000);
    check("b2b0_inst", ID_inst, 32'hDEAD_BEEF);

    #1;  // t=62
    IF_next_pc = 32'h0000_1004;
    IF_inst    = 32'h8C01_0004;
    #1;  // t=63: input change must not reach outputs before an edge
    check("nocomb_pc", ID_next_pc, 32'h0000_1000);
    check("nocomb_inst", ID_inst, 32'hDEAD_BEEF);
    #8;  // t=71
    check("b2b1_pc", ID_next_pc, 32'h0000_1004);
    check("b2b1_inst", ID_inst, 32'h8C01_0004);
    #10; // t=81
    check("b2b_hold_pc", ID_next_pc, 32'h0000_1004);
    check("b2b_hold_inst", ID_inst, 32'h8C01_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
